// File: rtl/operand_capture.sv
// rtl/operand_capture.sv - operand latch and start-pulse front end for the sequential multiplier
//
// Synchronises the operand switches and the active-low start button, debounces the button,
// latches the operands on each clean press and issues a one-cycle start pulse. The operands
// are then held and busy is reported until mult_ready arrives or the wait times out.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   sw_data      raw switch operands {multiplicand, multiplier}, asynchronous
//   btn_n        raw start pushbutton, active-low, asynchronous
//   mult_ready   completion pulse from the multiplier
//   start        one-cycle start pulse to the multiplier
//   data_out     latched operands, stable from start until the next accepted press
//   neg_expected sign of the product implied by the latched operands
//   busy         high while a multiplication is being started or awaited
//   overrun      sticky: a press arrived while busy
//   timeout      sticky: the wait expired without mult_ready
module operand_capture #(
    parameter int WIDTH           = 10,
    parameter int WIDTH_MLTND     = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             btn_n,
    input  logic             mult_ready,
    output logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             neg_expected,
    output logic             busy,
    output logic             overrun,
    output logic             timeout
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int TOW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] btn_sff;
    logic [WIDTH-1:0]       sw_sff [SYNC_STAGES];
    logic                   btn_sync;
    logic [WIDTH-1:0]       sw_sync;

    logic                   btn_stable;
    logic                   btn_stable_d;
    logic [DBW-1:0]         db_cnt;
    logic                   press_evt;

    logic [TOW-1:0]         to_cnt;

    assign btn_sync = btn_sff[SYNC_STAGES-1];
    assign sw_sync  = sw_sff[SYNC_STAGES-1];

    // Synchronisers. The button chain resets to the released level so reset never looks
    // like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sff <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sff[i] <= '0;
            end
        end else begin
            btn_sff   <= {btn_sff[SYNC_STAGES-2:0], btn_n};
            sw_sff[0] <= sw_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sff[i] <= sw_sff[i-1];
            end
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_stable   <= 1'b1;
            btn_stable_d <= 1'b1;
            db_cnt       <= '0;
        end else begin
            btn_stable_d <= btn_stable;
            if (btn_sync != btn_stable) begin
                if (db_cnt == DB_LAST) begin
                    btn_stable <= btn_sync;
                    db_cnt     <= '0;
                end else begin
                    db_cnt <= db_cnt + DBW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Only the accepted high-to-low transition is an event; release is silent.
    assign press_evt = btn_stable_d & ~btn_stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press_evt) state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                // mult_ready takes priority over an expiring timeout in the same cycle.
                if (mult_ready || (to_cnt == TO_LAST)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out     <= '0;
            neg_expected <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
            to_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_evt) begin
                        data_out     <= sw_sync;
                        neg_expected <= sw_sync[WIDTH-1] ^ sw_sync[WIDTH_MLTND-1];
                        overrun      <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                START: begin
                    to_cnt <= '0;
                    if (press_evt) overrun <= 1'b1;
                end
                WAIT: begin
                    // A press here is dropped even if the multiplier finishes this cycle.
                    if (press_evt) overrun <= 1'b1;
                    if (!mult_ready) begin
                        if (to_cnt == TO_LAST) begin
                            timeout <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + TOW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign start = (state == START);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_operand_capture.sv
// tb/tb_operand_capture.sv - self-checking bench for operand_capture
module tb_operand_capture;

    localparam int W    = 10;
    localparam int WM   = 5;
    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int TO   = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_data;
    logic         btn_n;
    logic         mult_ready;
    logic         start;
    logic [W-1:0] data_out;
    logic         neg_expected;
    logic         busy;
    logic         overrun;
    logic         timeout;

    operand_capture #(
        .WIDTH(W), .WIDTH_MLTND(WM), .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .sw_data(sw_data), .btn_n(btn_n), .mult_ready(mult_ready),
        .start(start), .data_out(data_out), .neg_expected(neg_expected), .busy(busy),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_start = 0;

    // Behavioural model: input history stands in for the synchroniser, a run-length of
    // disagreement for the debouncer, and a phase plus elapsed-wait count for the controller.
    bit         m_valid = 0;
    bit         hb [SYNC];
    logic [W-1:0] hs [SYNC];
    bit         m_stable;
    int         m_run;
    bit         m_evt;
    int         m_phase;      // 0 idle, 1 start cycle, 2 waiting
    int         m_waited;
    logic [W-1:0] m_data;
    bit         m_neg, m_over, m_to;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) begin hb[i] = 1'b1; hs[i] = '0; end
            m_stable = 1; m_run = 0; m_evt = 0; m_phase = 0; m_waited = 0;
            m_data = '0; m_neg = 0; m_over = 0; m_to = 0;
            m_valid = 1;
        end else if (m_valid) begin
            bit           b_old;
            logic [W-1:0] s_old;
            bit           evt_next;
            b_old = hb[SYNC-1];
            s_old = hs[SYNC-1];
            if (m_phase == 0) begin
                if (m_evt) begin
                    m_data = s_old; m_neg = s_old[W-1] ^ s_old[WM-1];
                    m_over = 0; m_to = 0; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_evt) m_over = 1;
                m_phase = 2; m_waited = 0;
            end else begin
                if (m_evt) m_over = 1;
                if (mult_ready) m_phase = 0;
                else begin
                    m_waited++;
                    if (m_waited == TO) begin m_to = 1; m_phase = 0; end
                end
            end
            evt_next = 0;
            if (b_old != m_stable) begin
                m_run++;
                if (m_run == DB) begin
                    m_stable = b_old; m_run = 0;
                    if (!m_stable) evt_next = 1;
                end
            end else m_run = 0;
            m_evt = evt_next;
            for (int i = SYNC-1; i > 0; i--) begin hb[i] = hb[i-1]; hs[i] = hs[i-1]; end
            hb[0] = btn_n; hs[0] = sw_data;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if (start !== (m_phase == 1) || busy !== (m_phase != 0) || data_out !== m_data ||
                neg_expected !== m_neg || overrun !== m_over || timeout !== m_to) begin
                fails++;
                $display("FAIL model t=%0t got start=%b busy=%b data=%h neg=%b ovr=%b to=%b exp start=%b busy=%b data=%h neg=%b ovr=%b to=%b",
                         $time, start, busy, data_out, neg_expected, overrun, timeout,
                         m_phase == 1, m_phase != 0, m_data, m_neg, m_over, m_to);
            end
            if (start === 1'b1) n_start++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles from the input change (made at a negedge) until start is seen.
    task automatic wait_start(input string name, output int n);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (start === 1'b1) break;
        end
        if (start !== 1'b1) begin
            tests++; fails++;
            $display("FAIL %s start never seen within %0d cycles", name, n);
        end
    endtask

    task automatic finish_op();
        btn_n = 1'b1;
        mult_ready = 1'b1; cyc(1); mult_ready = 1'b0;
        cyc(12);
    endtask

    initial begin
        int n, s0, hold;
        rst = 1'b1; btn_n = 1'b0; sw_data = '0; mult_ready = 1'b0;
        cyc(2);
        check("reset_outputs", {start, busy, overrun, timeout, neg_expected, data_out}, 0);
        rst = 1'b0; btn_n = 1'b1;
        cyc(10);
        check("reset_no_start", n_start, 0);

        // Clean press
        sw_data = 10'b11101_00011;
        btn_n = 1'b0;
        wait_start("clean_latency", n);
        check("clean_latency", n, SYNC + DB + 1);
        cyc(1);
        check("clean_data", data_out, 'h3A3);
        check("clean_neg", neg_expected, 1);
        check("clean_busy", busy, 1);
        btn_n = 1'b1; cyc(2);
        finish_op();
        check("clean_idle", busy, 0);

        // Bounce every 2 cycles, then a stable low
        s0 = n_start;
        sw_data = 10'h155;
        for (int i = 0; i < 10; i++) begin btn_n = ~btn_n; cyc(2); end
        check("bounce_no_start", n_start, s0);
        btn_n = 1'b0;
        wait_start("bounce_latency", n);
        check("bounce_latency", n, SYNC + DB + 1);
        finish_op();
        check("bounce_one_start", n_start, s0 + 1);

        // Overrun during WAIT, then mult_ready on the last WAIT cycle
        s0 = n_start;
        sw_data = 10'h3A3;
        btn_n = 1'b0; cyc(4);
        btn_n = 1'b1; cyc(4);
        sw_data = 10'h0FF;
        btn_n = 1'b0;
        n = 0;
        while (overrun !== 1'b1 && n < 20) begin cyc(1); n++; end
        mult_ready = 1'b1; cyc(1); mult_ready = 1'b0;
        check("ovr_flag", overrun, 1);
        check("ovr_data", data_out, 'h3A3);
        check("ovr_busy", busy, 0);
        check("ready_beats_timeout", timeout, 0);
        btn_n = 1'b1; cyc(12);
        check("ovr_one_start", n_start, s0 + 1);

        // Timeout
        sw_data = 10'h2C7;
        btn_n = 1'b0;
        wait_start("to_start", n);
        n = 0;
        while (busy === 1'b1 && n < 30) begin cyc(1); n++; end
        check("to_busy_len", n, TO + 1);
        check("to_flag", timeout, 1);
        btn_n = 1'b1; cyc(8);
        btn_n = 1'b0;
        wait_start("to_clear_start", n);
        check("to_cleared", timeout, 0);
        finish_op();

        // Reset mid-WAIT
        btn_n = 1'b0;
        wait_start("rst_start", n);
        cyc(2);
        rst = 1'b1; btn_n = 1'b1; cyc(1); rst = 1'b0;
        mult_ready = 1'b1; cyc(1); mult_ready = 1'b0;
        check("rst_mid_outputs", {start, busy, overrun, timeout, neg_expected, data_out}, 0);
        s0 = n_start;
        cyc(12);
        check("rst_mid_no_start", n_start, s0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            btn_n = $urandom_range(0, 1);
            hold = $urandom_range(1, 9);
            for (int j = 0; j < hold; j++) begin
                if ($urandom_range(0, 3) == 0) sw_data = W'($urandom);
                mult_ready = ($urandom_range(0, 5) == 0);
                rst = ($urandom_range(0, 499) == 0);
                cyc(1);
            end
        end
        rst = 1'b0; mult_ready = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
